saturn_fetch_sequencer: RTL
===========================

// Module: saturn_fetch_sequencer
// PURPOSE
//  Owns the program counter and paces saturn_decoder one nibble at a time.
//  Each nibble is read from memory over a req/ack bus, presented to the decoder with a
//  one-cycle decode enable, and the PC is advanced from the decoder's inc_pc / dec_error.
//  Also owns the free-running cycle counter, the debug-enable strobe and halt-on-error.
// PARAMETERS
//  RESET_PC     20'h00000  PC value after reset
//  BUS_TIMEOUT  15         max FETCH cycles without ack before bus error (1..255)
// PORTS
//  i_clk         in   1   clock; all logic on posedge
//  i_reset       in   1   synchronous reset, active-low (asserted when 0)
//  i_run         in   1   1 = sequence nibbles; 0 = stop at next nibble boundary
//  i_load_pc     in   1   load i_new_pc (honoured in IDLE and ADVANCE only)
//  i_new_pc      in   20  jump/start address
//  o_bus_req     out  1   nibble read request
//  o_bus_addr    out  20  read address, stable while o_bus_req=1
//  i_bus_ack     in   1   read data valid; sampled only while o_bus_req=1
//  i_bus_nibble  in   4   read data, valid with i_bus_ack
//  o_en_dec      out  1   decoder enable, one-cycle pulse per nibble
//  o_en_dbg      out  1   debugger enable, one-cycle pulse per nibble
//  o_stalled     out  1   decoder stall
//  o_pc          out  20  PC of nibble presented to decoder
//  o_nibble      out  4   nibble presented to decoder
//  i_inc_pc      in   1   decoder request to advance PC
//  i_dec_error   in   1   decoder error flag
//  o_cycles      out  32  cycle counter
//  o_halted      out  1   sticky halt
//  o_bus_error   out  1   sticky bus timeout flag
// BEHAVIOUR
//  Reset (i_reset=0 at posedge): state=IDLE, PC=RESET_PC, o_bus_req=0, o_bus_addr=0,
//   o_en_dec=0, o_en_dbg=0, o_stalled=1, o_nibble=0, o_cycles=0, o_halted=0,
//   o_bus_error=0, timeout count=0. Reset overrides everything. Reset during FETCH drops
//   o_bus_req next cycle; a late ack is ignored.
//  FSM: IDLE, FETCH, DECODE, ADVANCE, HALT. All outputs registered.
//  IDLE: o_stalled=1. i_load_pc=1 -> PC<=i_new_pc. i_run=1 -> FETCH.
//  FETCH: o_bus_req=1, o_bus_addr=PC, o_stalled=1. Ack at a posedge -> o_nibble<=i_bus_nibble,
//   o_bus_req<=0, -> DECODE. No ack and timeout count==BUS_TIMEOUT-1 -> o_bus_req<=0,
//   o_bus_error<=1, o_halted<=1, -> HALT. i_run ignored until the handshake completes.
//  DECODE: exactly 1 cycle. o_en_dec=1, o_stalled=0, o_pc/o_nibble stable. -> ADVANCE.
//  ADVANCE: 1 cycle. o_en_dbg=1, o_stalled=1. Samples the decoder's registered outputs.
//   Priority: i_dec_error=1 -> o_halted<=1, -> HALT, PC unchanged;
//   else i_load_pc=1 -> PC<=i_new_pc; else i_inc_pc=1 -> PC<=PC+1 (mod 2^20, FFFFF->00000).
//   Then i_run=1 -> FETCH, else -> IDLE.
//  HALT: terminal until reset. o_bus_req=0, o_en_dec=0, o_stalled=1. Ignores all inputs.
//  Throughput: zero-wait bus gives 1 nibble / 3 cycles (FETCH, DECODE, ADVANCE).
//  o_cycles: +1 on every non-reset cycle not in HALT. Wraps at 2^32.
//  Timeout count clears on entering FETCH and increments each FETCH cycle without ack.
//  Ack while o_bus_req=0 has no effect.
// STRUCTURE
//  Shared include saturn_defs.vh:
//   - SATURN_ADDR_W=20, SATURN_NIBBLE_W=4
//   - FSM state encodings SEQ_IDLE..SEQ_HALT (3 bits), shared with debugger/trace.
//  No sub-module. Timeout counter and PC incrementer are inline. The top level instantiates
//  this block next to saturn_decoder, wired o_en_dec->i_en_dec, o_pc->i_pc, etc.
// TESTING
//  1 Reset, load 12345 in IDLE, run, zero-wait ack nibbles 0,1 -> o_bus_addr 12345 then 12346;
//    o_en_dec pulses exactly 3 cycles apart; o_nibble=0 then 1.
//  2 Ack delayed 5 cycles -> o_bus_req and o_bus_addr held 5 cycles; o_stalled=1 throughout;
//    no o_en_dec pulse before ack.
//  3 No ack, BUS_TIMEOUT=15 -> after 15 FETCH cycles o_bus_error=1, o_halted=1, o_bus_req=0;
//    o_cycles frozen after that.
//  4 i_dec_error=1 in ADVANCE -> HALT; PC unchanged; o_halted stays 1 with later inputs;
//    leaves HALT only via i_reset=0.
//  5 PC=FFFFF with i_inc_pc=1 -> next o_bus_addr 00000. i_load_pc=1 and i_inc_pc=1 together
//    in ADVANCE with i_new_pc=0ABCD -> next fetch address 0ABCD.
//  6 i_run=0 mid-FETCH -> fetch completes, one DECODE+ADVANCE, then IDLE. i_reset=0 mid-FETCH
//    -> all outputs at reset values next cycle; an ack one cycle later is ignored.

Source files
------------

// File: rtl/saturn_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// saturn_fetch_sequencer_pkg
//   Shared definitions for the Saturn fetch sequencer and the blocks that
//   observe its state (debugger, trace).
//   - SATURN_ADDR_W / SATURN_NIBBLE_W : program address and nibble widths
//   - seqState_t and SEQ_* codes      : 3-bit sequencer state encodings
//   - pcIncrement()                   : PC + 1, wrapping modulo 2^20
// ---------------------------------------------------------------------------
package saturn_fetch_sequencer_pkg;

  localparam int SATURN_ADDR_W   = 20;
  localparam int SATURN_NIBBLE_W = 4;

  typedef logic [2:0] seqState_t;

  // Encodings are fixed so the debugger and trace logic can decode them.
  localparam seqState_t SEQ_IDLE    = 3'd0;
  localparam seqState_t SEQ_FETCH   = 3'd1;
  localparam seqState_t SEQ_DECODE  = 3'd2;
  localparam seqState_t SEQ_ADVANCE = 3'd3;
  localparam seqState_t SEQ_HALT    = 3'd4;

  // Natural overflow of the 20-bit add gives the FFFFF -> 00000 wrap.
  function automatic logic [SATURN_ADDR_W-1:0] pcIncrement(
    input logic [SATURN_ADDR_W-1:0] pc
  );
    return pc + SATURN_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/saturn_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// saturn_fetch_sequencer
//   Owns the program counter and paces the decoder one nibble at a time:
//   FETCH reads a nibble over a req/ack bus, DECODE pulses the decoder
//   enable, ADVANCE pulses the debugger enable and moves the PC from the
//   decoder's inc_pc / dec_error. Also keeps a free-running cycle counter,
//   a bus-timeout detector and a sticky halt.
//
//   Ports
//     i_clk, i_reset          clock, synchronous active-low reset
//     i_run                   sequence nibbles while 1
//     i_load_pc, i_new_pc     PC load (IDLE and ADVANCE only)
//     o_bus_req, o_bus_addr   nibble read request and address
//     i_bus_ack, i_bus_nibble read completion and data
//     o_en_dec, o_en_dbg      one-cycle decoder / debugger enables
//     o_stalled               decoder stall
//     o_pc, o_nibble          PC and nibble presented to the decoder
//     i_inc_pc, i_dec_error   decoder results, sampled in ADVANCE
//     o_cycles                cycle counter (frozen in HALT)
//     o_halted, o_bus_error   sticky halt and bus timeout flags
// ---------------------------------------------------------------------------
module saturn_fetch_sequencer
  import saturn_fetch_sequencer_pkg::*;
#(
  parameter logic [SATURN_ADDR_W-1:0] RESET_PC    = 20'h00000,
  parameter int                       BUS_TIMEOUT = 15
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_run,
  input  logic                       i_load_pc,
  input  logic [SATURN_ADDR_W-1:0]   i_new_pc,
  output logic                       o_bus_req,
  output logic [SATURN_ADDR_W-1:0]   o_bus_addr,
  input  logic                       i_bus_ack,
  input  logic [SATURN_NIBBLE_W-1:0] i_bus_nibble,
  output logic                       o_en_dec,
  output logic                       o_en_dbg,
  output logic                       o_stalled,
  output logic [SATURN_ADDR_W-1:0]   o_pc,
  output logic [SATURN_NIBBLE_W-1:0] o_nibble,
  input  logic                       i_inc_pc,
  input  logic                       i_dec_error,
  output logic [31:0]                o_cycles,
  output logic                       o_halted,
  output logic                       o_bus_error
);

  // Last count value before a fetch is declared timed out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

  seqState_t                  r_state;
  logic [SATURN_ADDR_W-1:0]   r_pc;
  logic                       r_busReq;
  logic [SATURN_ADDR_W-1:0]   r_busAddr;
  logic                       r_enDec;
  logic                       r_enDbg;
  logic                       r_stalled;
  logic [SATURN_NIBBLE_W-1:0] r_nibble;
  logic [31:0]                r_cycles;
  logic                       r_halted;
  logic                       r_busError;
  logic [7:0]                 r_timeoutCnt;

  logic [SATURN_ADDR_W-1:0]   w_idlePc;
  logic [SATURN_ADDR_W-1:0]   w_advancePc;

  // In IDLE a load and a run may arrive together; the first fetch must
  // then use the freshly loaded address.
  assign w_idlePc = i_load_pc ? i_new_pc : r_pc;

  // ADVANCE priority below dec_error: an explicit jump beats increment.
  always_comb begin
    w_advancePc = r_pc;
    if (i_load_pc) begin
      w_advancePc = i_new_pc;
    end else if (i_inc_pc) begin
      w_advancePc = pcIncrement(r_pc);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= SEQ_IDLE;
      r_pc         <= RESET_PC;
      r_busReq     <= 1'b0;
      r_busAddr    <= '0;
      r_enDec      <= 1'b0;
      r_enDbg      <= 1'b0;
      r_stalled    <= 1'b1;
      r_nibble     <= '0;
      r_cycles     <= '0;
      r_halted     <= 1'b0;
      r_busError   <= 1'b0;
      r_timeoutCnt <= '0;
    end else begin
      // The cycle counter stops once the sequencer has halted.
      if (r_state != SEQ_HALT) begin
        r_cycles <= r_cycles + 32'd1;
      end

      case (r_state)
        SEQ_IDLE: begin
          r_stalled <= 1'b1;
          r_pc      <= w_idlePc;
          if (i_run) begin
            r_state      <= SEQ_FETCH;
            r_busReq     <= 1'b1;
            r_busAddr    <= w_idlePc;
            r_timeoutCnt <= '0;
          end
        end

        // i_run and i_load_pc are ignored until the handshake completes.
        SEQ_FETCH: begin
          if (i_bus_ack) begin
            r_nibble  <= i_bus_nibble;
            r_busReq  <= 1'b0;
            r_enDec   <= 1'b1;
            r_stalled <= 1'b0;
            r_state   <= SEQ_DECODE;
          end else if (r_timeoutCnt == TIMEOUT_LAST) begin
            r_busReq   <= 1'b0;
            r_busError <= 1'b1;
            r_halted   <= 1'b1;
            r_state    <= SEQ_HALT;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + 8'd1;
          end
        end

        SEQ_DECODE: begin
          r_enDec   <= 1'b0;
          r_enDbg   <= 1'b1;
          r_stalled <= 1'b1;
          r_state   <= SEQ_ADVANCE;
        end

        // Decoder outputs are valid here, one cycle after the decode enable.
        SEQ_ADVANCE: begin
          r_enDbg <= 1'b0;
          if (i_dec_error) begin
            r_halted <= 1'b1;
            r_state  <= SEQ_HALT;
          end else begin
            r_pc <= w_advancePc;
            if (i_run) begin
              r_state      <= SEQ_FETCH;
              r_busReq     <= 1'b1;
              r_busAddr    <= w_advancePc;
              r_timeoutCnt <= '0;
            end else begin
              r_state <= SEQ_IDLE;
            end
          end
        end

        // Terminal until reset; every output holds its halted value.
        SEQ_HALT: begin
          r_busReq  <= 1'b0;
          r_enDec   <= 1'b0;
          r_enDbg   <= 1'b0;
          r_stalled <= 1'b1;
        end

        default: begin
          r_state   <= SEQ_IDLE;
          r_busReq  <= 1'b0;
          r_enDec   <= 1'b0;
          r_enDbg   <= 1'b0;
          r_stalled <= 1'b1;
        end
      endcase
    end
  end

  assign o_bus_req   = r_busReq;
  assign o_bus_addr  = r_busAddr;
  assign o_en_dec    = r_enDec;
  assign o_en_dbg    = r_enDbg;
  assign o_stalled   = r_stalled;
  assign o_pc        = r_pc;
  assign o_nibble    = r_nibble;
  assign o_cycles    = r_cycles;
  assign o_halted    = r_halted;
  assign o_bus_error = r_busError;

endmodule
